// File: rtl/nibble_serial_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for the nibble-serial adder.
// The sequencer sits on the slave side; the requester drives the master side.
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// W-bit add/subtract built from one 4-bit adder reused over NIBBLES cycles,
// LSB nibble first, with the carry held in a register between nibbles.

// Four chained full-adder slices.
module FourBitAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  output logic [3:0] S,
  output logic       C_out
);
  logic [4:0] c;

  assign c[0] = C_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign C_out = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [NIBBLES-1:0][3:0] a_q;
  logic [NIBBLES-1:0][3:0] b_q;
  logic [NIBBLES-1:0][3:0] sum_q;
  logic                   carry_q;
  logic [IW-1:0]          idx_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   c_out_q;
  logic                   ovf_q;

  logic [3:0] fa_a;
  logic [3:0] fa_b;
  logic [3:0] fa_s;
  logic       fa_co;
  logic       last_nib;

  assign fa_a     = a_q[idx_q];
  assign fa_b     = b_q[idx_q];
  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  FourBitAdder u_fa (
    .A    (fa_a),
    .B    (fa_b),
    .C_in (carry_q),
    .S    (fa_s),
    .C_out(fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // Subtract as a + ~b + 1: invert b once here, seed the carry with 1.
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q[idx_q] <= fa_s;
          carry_q      <= fa_co;
          idx_q        <= idx_q + IW'(1);
          if (last_nib) begin
            // Signed overflow: operands agree in sign but the result does not.
            c_out_q <= fa_co;
            ovf_q   <= (fa_a[3] == fa_b[3]) & (fa_s[3] != fa_a[3]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for the nibble-serial adder: handshake timing, carry ripple,
// signed overflow, subtract, back-to-back start, start-while-busy, mid-run reset.
module tb_nibble_serial_adder_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nerr = 0;
  int   nchk = 0;
  int   done_cnt = 0;

  nibble_serial_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the start is accepted at the following posedge.
  // Returns at the negedge of the first busy cycle.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.sub   = $urandom_range(0, 1);
  endtask

  // Checks four busy cycles then the done cycle. poke >= 0 raises a stray
  // start during that busy cycle. Returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input logic [W-1:0] exp_sum,
                           input logic exp_c, input logic exp_ov, input int poke);
    for (int i = 0; i < NIBBLES; i++) begin
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      chk({tag, " done_low"}, 32'(bus.done), 32'd0);
      if (i == 0) chk({tag, " sum_cleared"}, 32'(bus.sum), 32'd0);
      if (i == poke) begin
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h1111;
        bus.sub   = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, " done"}, 32'(bus.done), 32'd1);
    chk({tag, " busy_low"}, 32'(bus.busy), 32'd0);
    chk({tag, " sum"}, 32'(bus.sum), 32'(exp_sum));
    chk({tag, " c_out"}, 32'(bus.c_out), 32'(exp_c));
    chk({tag, " overflow"}, 32'(bus.overflow), 32'(exp_ov));
  endtask

  initial begin
    int dc0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst sum", 32'(bus.sum), 32'd0);
    chk("rst c_out", 32'(bus.c_out), 32'd0);
    chk("rst overflow", 32'(bus.overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle done", 32'(bus.done), 32'd0);

    // 1: basic add and latency
    dc0 = done_cnt;
    launch(16'h0007, 16'h0003, 1'b0);
    wait_done("add7+3", 16'h000A, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("add7+3 done_pulse", 32'(bus.done), 32'd0);
    chk("add7+3 sum_held", 32'(bus.sum), 32'h000A);
    chk("add7+3 done_cnt", 32'(done_cnt - dc0), 32'd1);

    // 2: carry ripples through all nibbles
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_done("addFFFF+1", 16'h0000, 1'b1, 1'b0, -1);
    @(negedge clk);

    // 3: signed overflow
    launch(16'h7FFF, 16'h0001, 1'b0);
    wait_done("add7FFF+1", 16'h8000, 1'b0, 1'b1, -1);
    @(negedge clk);
    launch(16'h8000, 16'h8000, 1'b0);
    wait_done("add8000+8000", 16'h0000, 1'b1, 1'b1, -1);
    @(negedge clk);

    // 4: subtract, second started in the DONE cycle
    dc0 = done_cnt;
    launch(16'h0005, 16'h0007, 1'b1);
    wait_done("sub5-7", 16'hFFFE, 1'b0, 1'b0, -1);
    launch(16'h0007, 16'h0005, 1'b1);
    wait_done("sub7-5", 16'h0002, 1'b1, 1'b0, -1);
    @(negedge clk);
    chk("b2b done_cnt", 32'(done_cnt - dc0), 32'd2);
    chk("b2b idle_done", 32'(bus.done), 32'd0);

    // 5: start while busy is ignored
    dc0 = done_cnt;
    launch(16'h0002, 16'h0005, 1'b0);
    wait_done("ignore", 16'h0007, 1'b0, 1'b0, 1);
    repeat (3) @(negedge clk);
    chk("ignore done_cnt", 32'(done_cnt - dc0), 32'd1);
    chk("ignore idle_busy", 32'(bus.busy), 32'd0);
    chk("ignore sum_held", 32'(bus.sum), 32'h0007);

    // 6: reset mid-run aborts without done
    dc0 = done_cnt;
    launch(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort sum", 32'(bus.sum), 32'd0);
    chk("abort c_out", 32'(bus.c_out), 32'd0);
    chk("abort overflow", 32'(bus.overflow), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort done_cnt", 32'(done_cnt - dc0), 32'd0);
    chk("abort idle_busy", 32'(bus.busy), 32'd0);
    launch(16'h0003, 16'h0005, 1'b0);
    wait_done("post_rst", 16'h0008, 1'b0, 1'b0, -1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
